eth_bd_ram_arbiter: RTL and testbench

//  Shares one 256x32 byte-writable single-port buffer-descriptor SRAM
//  (vs_hdsp_256x32_bw) between NREQ requesters (0=host/WB, 1=TX, 2=RX).

---
 rtl/eth_bd_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_eth_bd_ram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_bd_ram_arbiter.sv
// Arbitrates host/TX/RX buffer-descriptor accesses onto one single-port SRAM.
// States: IDLE | no access in flight; CMD | command on SRAM pins; RESP | ack + read data.
module eth_bd_ram_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int RR   = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        we_i,
    input  logic [NREQ*DW/8-1:0]   be_i,
    input  logic [NREQ*AW-1:0]     addr_i,
    input  logic [NREQ*DW-1:0]     wdata_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [DW-1:0]          rdata_o,
    output logic                   busy_o,
    output logic                   CEN,
    output logic [DW/8-1:0]        WEN,
    output logic                   OEN,
    output logic [AW-1:0]          ADR,
    output logic [DW-1:0]          DI,
    input  logic [DW-1:0]          DOUT
);
    localparam int BW = DW / 8;
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RESP = 2'd2} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   ptr;

    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] cand;
    logic            found;
    logic [OW-1:0]   win;
    logic [OW-1:0]   ptr_nxt;
    logic            win_we;
    logic [BW-1:0]   win_be;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    int              k;

    // The current owner is excluded in RESP so a held req cannot monopolise the SRAM.
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        cand  = req_i & ~((state == RESP) ? owner_oh : '0);
        found = 1'b0;
        win   = '0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (RR != 0) begin
                k = int'(ptr) + i;
                if (k >= NREQ) k = k - NREQ;
            end else begin
                k = NREQ - 1 - i;
            end
            if (!found && cand[OW'(k)]) begin
                found = 1'b1;
                win   = OW'(k);
            end
        end
        ptr_nxt   = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
        win_we    = 1'b0;
        win_be    = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (OW'(j) == win) begin
                win_we    = we_i[j];
                win_be    = be_i[j*BW +: BW];
                win_addr  = addr_i[j*AW +: AW];
                win_wdata = wdata_i[j*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            CEN   <= 1'b1;
            WEN   <= '1;
            ADR   <= '0;
            DI    <= '0;
            ack_o <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            ack_o <= '0;
            case (state)
                CMD: begin
                    CEN   <= 1'b1;
                    WEN   <= '1;
                    ack_o <= owner_oh;
                    state <= RESP;
                end
                IDLE, RESP: begin
                    if (found) begin
                        owner <= win;
                        ptr   <= ptr_nxt;
                        CEN   <= 1'b0;
                        WEN   <= win_we ? ~win_be : '1;
                        ADR   <= win_addr;
                        DI    <= win_wdata;
                        state <= CMD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign OEN     = 1'b0;
    assign rdata_o = DOUT;

endmodule

// File: tb/tb_eth_bd_ram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each with its own SRAM model.
module tb_eth_bd_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req_rr, we_rr, ack_rr, req_fp, we_fp, ack_fp;
    logic [11:0] be_rr, be_fp;
    logic [23:0] addr_rr, addr_fp;
    logic [95:0] wdata_rr, wdata_fp;
    logic [31:0] rdata_rr, rdata_fp, di_rr, di_fp, dout_rr, dout_fp;
    logic        busy_rr, busy_fp, cen_rr, cen_fp, oen_rr, oen_fp;
    logic [3:0]  wen_rr, wen_fp;
    logic [7:0]  adr_rr, adr_fp;
    logic [31:0] mem_rr [256];
    logic [31:0] mem_fp [256];

    eth_bd_ram_arbiter #(.NREQ(3), .AW(8), .DW(32), .RR(1)) dut_rr (
        .Clk(clk), .Reset(rst), .req_i(req_rr), .we_i(we_rr), .be_i(be_rr),
        .addr_i(addr_rr), .wdata_i(wdata_rr), .ack_o(ack_rr), .rdata_o(rdata_rr),
        .busy_o(busy_rr), .CEN(cen_rr), .WEN(wen_rr), .OEN(oen_rr), .ADR(adr_rr),
        .DI(di_rr), .DOUT(dout_rr));

    eth_bd_ram_arbiter #(.NREQ(3), .AW(8), .DW(32), .RR(0)) dut_fp (
        .Clk(clk), .Reset(rst), .req_i(req_fp), .we_i(we_fp), .be_i(be_fp),
        .addr_i(addr_fp), .wdata_i(wdata_fp), .ack_o(ack_fp), .rdata_o(rdata_fp),
        .busy_o(busy_fp), .CEN(cen_fp), .WEN(wen_fp), .OEN(oen_fp), .ADR(adr_fp),
        .DI(di_fp), .DOUT(dout_fp));

    // Byte-writable SRAM models: output data appears the cycle after capture.
    always @(posedge clk) begin
        if (!cen_rr) begin
            for (int b = 0; b < 4; b++)
                if (!wen_rr[b]) mem_rr[adr_rr][8*b +: 8] <= di_rr[8*b +: 8];
            dout_rr <= mem_rr[adr_rr];
        end
        if (!cen_fp) begin
            for (int b = 0; b < 4; b++)
                if (!wen_fp[b]) mem_fp[adr_fp][8*b +: 8] <= di_fp[8*b +: 8];
            dout_fp <= mem_fp[adr_fp];
        end
    end

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack_rr !== 3'b000) begin
            checks++;
            if (q_rr.size() == 0) begin
                failures++;
                $display("FAIL rr_unexpected_ack actual=%b required=none", ack_rr);
            end else begin
                e = q_rr.pop_front();
                if (ack_rr !== e.ack || (e.chk && rdata_rr !== e.data)) begin
                    failures++;
                    $display("FAIL rr_ack_data actual ack=%b data=%h required ack=%b data=%h",
                             ack_rr, rdata_rr, e.ack, e.data);
                end
            end
        end
        if (ack_fp !== 3'b000) begin
            checks++;
            if (q_fp.size() == 0) begin
                failures++;
                $display("FAIL fp_unexpected_ack actual=%b required=none", ack_fp);
            end else begin
                e = q_fp.pop_front();
                if (ack_fp !== e.ack || (e.chk && rdata_fp !== e.data)) begin
                    failures++;
                    $display("FAIL fp_ack_data actual ack=%b data=%h required ack=%b data=%h",
                             ack_fp, rdata_fp, e.ack, e.data);
                end
            end
        end
    end

    task automatic access(input int idx, input logic we, input logic [3:0] be,
                          input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic chk_d,
                          input logic [3:0] exp_wen, input string nm);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        q_rr.push_back('{oh, rd, chk_d});
        @(posedge clk); #1;
        req_rr[idx]            = 1'b1;
        we_rr[idx]             = we;
        be_rr[idx*4 +: 4]      = be;
        addr_rr[idx*8 +: 8]    = addr;
        wdata_rr[idx*32 +: 32] = wd;
        @(negedge clk);
        check({nm, "_c0_busy"}, 64'(busy_rr), 64'd0);
        @(negedge clk);
        check({nm, "_c1_cen"}, 64'(cen_rr), 64'd0);
        check({nm, "_c1_wen"}, 64'(wen_rr), 64'(exp_wen));
        check({nm, "_c1_adr"}, 64'(adr_rr), 64'(addr));
        if (we) check({nm, "_c1_di"}, 64'(di_rr), 64'(wd));
        @(negedge clk);
        check({nm, "_c2_ack"}, 64'(ack_rr), 64'(oh));
        check({nm, "_c2_cen"}, 64'(cen_rr), 64'd1);
        @(posedge clk); #1;
        req_rr[idx] = 1'b0;
    endtask

    logic [2:0] expa;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_rr[i] = 32'h0;
            mem_fp[i] = 32'h0;
        end
        req_rr = '0; we_rr = '0; be_rr = '0; addr_rr = '0; wdata_rr = '0;
        req_fp = '0; we_fp = '0; be_fp = '0; addr_fp = '0; wdata_fp = '0;
        repeat (2) @(negedge clk);
        check("rst_cen", 64'(cen_rr), 64'd1);
        check("rst_wen", 64'(wen_rr), 64'hF);
        check("rst_adr", 64'(adr_rr), 64'd0);
        check("rst_di", 64'(di_rr), 64'd0);
        check("rst_ack", 64'(ack_rr), 64'd0);
        check("rst_busy", 64'(busy_rr), 64'd0);
        check("oen", 64'({oen_rr, oen_fp}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        access(1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'h0, "wr_full");
        access(1, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 4'hF, "rd_full");
        access(1, 1'b1, 4'b0100, 8'h10, 32'h00AA0000, 32'h0, 1'b0, 4'b1011, "wr_byte");
        access(1, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEAABEEF, 1'b1, 4'hF, "rd_byte");

        // Reset while the command is on the SRAM pins.
        @(posedge clk); #1;
        req_rr[1] = 1'b1; we_rr[1] = 1'b0; addr_rr[15:8] = 8'h10;
        @(negedge clk);
        @(posedge clk); #2;
        check("mid_cmd_cen", 64'(cen_rr), 64'd0);
        check("mid_cmd_busy", 64'(busy_rr), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cen", 64'(cen_rr), 64'd1);
        check("mid_rst_ack", 64'(ack_rr), 64'd0);
        check("mid_rst_busy", 64'(busy_rr), 64'd0);
        req_rr[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_no_ack", 64'(ack_rr), 64'd0);
        end
        access(2, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEAABEEF, 1'b1, 4'hF, "rd_after_rst");

        // All three held high, round robin: 0,1,2,0,1,2 every other cycle.
        for (int n = 0; n < 6; n++) q_rr.push_back('{3'b001 << (n % 3), 32'hDEAABEEF, 1'b1});
        @(posedge clk); #1;
        we_rr = 3'b000; addr_rr = {8'h10, 8'h10, 8'h10}; req_rr = 3'b111;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            @(negedge clk);
            expa = (cyc >= 2 && cyc % 2 == 0) ? (3'b001 << ((cyc / 2 - 1) % 3)) : 3'b000;
            check("rr_order", 64'(ack_rr), 64'(expa));
            if (cyc == 12) req_rr = 3'b000;
        end
        @(negedge clk);
        check("rr_idle_after", 64'(busy_rr), 64'd0);

        // Fixed priority: 2,1,2,1 since the owner is excluded in RESP.
        for (int n = 0; n < 4; n++) q_fp.push_back('{(n % 2 == 0) ? 3'b100 : 3'b010, 32'h0, 1'b1});
        @(posedge clk); #1;
        we_fp = 3'b000; addr_fp = '0; req_fp = 3'b111;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            expa = (cyc >= 2 && cyc % 2 == 0) ? (((cyc / 2) % 2 == 1) ? 3'b100 : 3'b010) : 3'b000;
            check("fp_order", 64'(ack_fp), 64'(expa));
            if (cyc == 8) req_fp = 3'b000;
        end
        @(negedge clk);
        check("fp_idle_after", 64'(busy_fp), 64'd0);

        // Single requester re-requesting right after each ack: 3-cycle period.
        for (int n = 0; n < 3; n++) q_rr.push_back('{3'b100, 32'hDEAABEEF, 1'b1});
        @(posedge clk); #1;
        we_rr[2] = 1'b0; addr_rr[23:16] = 8'h10; req_rr[2] = 1'b1;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            check("toggle_ack", 64'(ack_rr[2]), 64'(cyc % 3 == 2));
            check("toggle_busy", 64'(busy_rr), 64'(cyc % 3 != 0));
            if (cyc % 3 == 2) begin
                req_rr[2] = 1'b0;
                if (cyc < 8) begin
                    @(posedge clk); #1;
                    req_rr[2] = 1'b1;
                end
            end
        end

        // Write with no byte enables is a plain read cycle, still acked.
        access(0, 1'b1, 4'h0, 8'h20, 32'h12345678, 32'h0, 1'b0, 4'hF, "wr_be0");
        access(0, 1'b0, 4'h0, 8'h20, 32'h0, 32'h0, 1'b1, 4'hF, "rd_be0");

        repeat (4) @(negedge clk);
        check("rr_queue_drained", 64'(q_rr.size()), 64'd0);
        check("fp_queue_drained", 64'(q_fp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
